// File: rtl/motor_pkg.sv
// ============================================================================
//  Module      : motor_pkg
//  Description : Shared definitions for the wheel PWM stage and FIFO decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package motor_pkg;

    localparam int c_para_w       = 15;
    // Command word layout: speed magnitude in the low bits, direction above it
    localparam int c_cmd_para_lsb = 0;
    localparam int c_cmd_para_msb = c_cmd_para_lsb + c_para_w - 1;
    localparam int c_cmd_dir_bit  = c_cmd_para_msb + 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_BRAKE = 2'd1,
        ST_DEAD  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/motor_pwm_gen_if.sv
// ============================================================================
//  Module      : motor_pwm_if
//  Description : Command/status bundle between wheel decoder and PWM stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface motor_pwm_if #(
    parameter int PARA_W = 15
);
    logic [PARA_W-1:0] para_in;
    logic              dir_in;
    logic              dir_out;
    logic              en_out;
    logic [PARA_W-1:0] duty_cur;
    logic              rev_busy;

    modport master (
        output para_in, dir_in,
        input  dir_out, en_out, duty_cur, rev_busy
    );

    modport slave (
        input  para_in, dir_in,
        output dir_out, en_out, duty_cur, rev_busy
    );
endinterface

`default_nettype wire

// File: rtl/duty_ramp.sv
// ============================================================================
//  Module      : duty_ramp
//  Description : Combinational slew step: move cur toward tgt by at most step,
//                never overshooting and never exceeding i_max.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module duty_ramp #(
    parameter int W = 16
) (
    input  wire logic [W-1:0] i_cur,
    input  wire logic [W-1:0] i_tgt,
    input  wire logic [W-1:0] i_step,
    input  wire logic [W-1:0] i_max,
    output logic      [W-1:0] o_next
);
    logic [W-1:0] w_diff;
    logic [W-1:0] w_mag;
    logic [W-1:0] w_sum;

    always_comb begin
        w_diff = (i_tgt >= i_cur) ? (i_tgt - i_cur) : (i_cur - i_tgt);
        w_mag  = (w_diff < i_step) ? w_diff : i_step;
        // Step is bounded by the distance to target, so neither direction can wrap
        if (i_tgt >= i_cur) begin
            w_sum  = i_cur + w_mag;
            o_next = (w_sum > i_max) ? i_max : w_sum;
        end else begin
            w_sum  = i_cur - w_mag;
            o_next = w_sum;
        end
    end
endmodule

`default_nettype wire

// File: rtl/motor_pwm_gen.sv
// ============================================================================
//  Module      : motor_pwm_gen
//  Description : Per-wheel H-bridge PWM with slew limiting and reversal dead time.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module motor_pwm_gen
    import motor_pkg::*;
#(
    parameter int PARA_W    = c_para_w,
    parameter int PERIOD    = 20000,
    parameter int RAMP_STEP = 64,
    parameter int DEADTIME  = 2
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    motor_pwm_if.slave   bus
);
    // One extra bit so a duty of exactly PERIOD and the ramp math never wrap
    localparam int c_w      = PARA_W + 1;
    localparam int c_dead_w = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

    localparam logic [c_w-1:0]      c_period    = c_w'(PERIOD);
    localparam logic [c_w-1:0]      c_last      = c_w'(PERIOD - 1);
    localparam logic [c_w-1:0]      c_step      = c_w'(RAMP_STEP);
    localparam logic [c_dead_w-1:0] c_dead_last = c_dead_w'(DEADTIME - 1);

    logic [c_w-1:0]      r_cnt;
    logic [c_w-1:0]      r_duty;
    logic [c_dead_w-1:0] r_dead;
    state_t              r_state;
    logic                r_dir;
    logic                r_en;

    logic                w_tick;
    logic                w_dir_match;
    logic [c_w-1:0]      w_para;
    logic [c_w-1:0]      w_tgt;
    logic [c_w-1:0]      w_ramp_tgt;
    logic [c_w-1:0]      w_next;

    assign w_tick      = (r_cnt == c_last);
    assign w_dir_match = (bus.dir_in == r_dir);
    assign w_para      = {1'b0, bus.para_in};
    assign w_tgt       = (w_para > c_period) ? c_period : w_para;
    // While braking the ramp heads for zero instead of the commanded speed
    assign w_ramp_tgt  = ((r_state == ST_BRAKE) && !w_dir_match) ? '0 : w_tgt;

    duty_ramp #(
        .W      (c_w)
    ) u_duty_ramp (
        .i_cur  (r_duty),
        .i_tgt  (w_ramp_tgt),
        .i_step (c_step),
        .i_max  (c_period),
        .o_next (w_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_duty  <= '0;
            r_dead  <= '0;
            r_state <= ST_RUN;
            r_dir   <= 1'b0;
            r_en    <= 1'b0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            r_en  <= (r_state != ST_DEAD) && (r_cnt < r_duty);

            if (w_tick) begin
                case (r_state)
                    ST_RUN: begin
                        if (w_dir_match) begin
                            r_duty <= w_next;
                        end else if (r_duty == '0) begin
                            r_state <= ST_DEAD;
                            r_dead  <= '0;
                        end else begin
                            r_state <= ST_BRAKE;
                        end
                    end
                    ST_BRAKE: begin
                        r_duty <= w_next;
                        if (w_dir_match) begin
                            r_state <= ST_RUN;
                        end else if (w_next == '0) begin
                            r_state <= ST_DEAD;
                            r_dead  <= '0;
                        end
                    end
                    ST_DEAD: begin
                        // Dead time always runs to completion, even if dir_in reverts
                        if (r_dead == c_dead_last) begin
                            r_dir   <= bus.dir_in;
                            r_state <= ST_RUN;
                            r_dead  <= '0;
                        end else begin
                            r_dead <= r_dead + 1'b1;
                        end
                    end
                    default: r_state <= ST_RUN;
                endcase
            end
        end
    end

    assign bus.dir_out  = r_dir;
    assign bus.en_out   = r_en;
    assign bus.duty_cur = r_duty[PARA_W-1:0];
    assign bus.rev_busy = (r_state != ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_motor_pwm_gen.sv
// ============================================================================
//  Module      : tb_motor_pwm_gen
//  Description : Directed, table-driven bench for motor_pwm_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_motor_pwm_gen;
    localparam int PARA_W    = 15;
    localparam int PERIOD    = 100;
    localparam int RAMP_STEP = 10;
    localparam int DEADTIME  = 2;

    typedef struct {
        logic [PARA_W-1:0] para;
        logic              dir;
        int                exp_duty;
        logic              exp_dir;
        logic              exp_busy;
        int                exp_en;   // en_out high cycles in the period ending at this tick
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   m_cnt;
    vec_t vecs[$];

    motor_pwm_if #(.PARA_W(PARA_W)) bus ();

    motor_pwm_gen #(
        .PARA_W    (PARA_W),
        .PERIOD    (PERIOD),
        .RAMP_STEP (RAMP_STEP),
        .DEADTIME  (DEADTIME)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference period counter, used only to find tick edges
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_cnt <= 0;
        else        m_cnt <= (m_cnt == PERIOD - 1) ? 0 : m_cnt + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input int para, input logic dir, input int duty,
                       input logic edir, input logic busy, input int en);
        vec_t v;
        v.para = PARA_W'(para); v.dir = dir; v.exp_duty = duty;
        v.exp_dir = edir; v.exp_busy = busy; v.exp_en = en;
        vecs.push_back(v);
    endtask

    // Advance to just after the next tick edge, counting en_out highs on the way
    task automatic next_tick(output int en_cnt);
        int n;
        en_cnt = 0;
        n = 0;
        do begin
            @(posedge clk); #1;
            if (bus.en_out === 1'b1) en_cnt++;
            n++;
        end while (m_cnt != 0 && n < 2 * PERIOD);
        if (m_cnt != 0) chk("tick_timeout", n, PERIOD);
    endtask

    task automatic check_outputs(input string tag, input int duty, input logic dir,
                                 input logic en, input logic busy);
        chk({tag, "_duty"}, int'(bus.duty_cur), duty);
        chk({tag, "_dir"},  int'(bus.dir_out),  int'(dir));
        chk({tag, "_en"},   int'(bus.en_out),   int'(en));
        chk({tag, "_busy"}, int'(bus.rev_busy), int'(busy));
    endtask

    initial begin
        int en_cnt;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.para_in = PARA_W'(50);
        bus.dir_in  = 1'b0;

        // Ramp up, clamp, ramp down
        add(50, 0, 10, 0, 0, 0);   add(50, 0, 20, 0, 0, 10);
        add(50, 0, 30, 0, 0, 20);  add(50, 0, 40, 0, 0, 30);
        add(50, 0, 50, 0, 0, 40);  add(50, 0, 50, 0, 0, 50);
        add(200, 0, 60, 0, 0, 50); add(200, 0, 70, 0, 0, 60);
        add(200, 0, 80, 0, 0, 70); add(200, 0, 90, 0, 0, 80);
        add(200, 0, 100, 0, 0, 90); add(200, 0, 100, 0, 0, 100);
        add(200, 0, 100, 0, 0, 100);
        add(50, 0, 90, 0, 0, 100); add(50, 0, 80, 0, 0, 90);
        add(50, 0, 70, 0, 0, 80);  add(50, 0, 60, 0, 0, 70);
        add(50, 0, 50, 0, 0, 60);  add(50, 0, 50, 0, 0, 50);
        // Brake aborted at duty 30
        add(50, 1, 50, 0, 1, 50);  add(50, 1, 40, 0, 1, 50);
        add(50, 1, 30, 0, 1, 40);  add(50, 0, 40, 0, 0, 30);
        add(50, 0, 50, 0, 0, 40);  add(50, 0, 50, 0, 0, 50);
        // Full reversal through dead time
        add(50, 1, 50, 0, 1, 50);  add(50, 1, 40, 0, 1, 50);
        add(50, 1, 30, 0, 1, 40);  add(50, 1, 20, 0, 1, 30);
        add(50, 1, 10, 0, 1, 20);  add(50, 1, 0, 0, 1, 10);
        add(50, 1, 0, 0, 1, 0);    add(50, 1, 0, 1, 0, 0);
        add(50, 1, 10, 1, 0, 0);   add(50, 1, 20, 1, 0, 10);
        add(50, 1, 30, 1, 0, 20);  add(50, 1, 40, 1, 0, 30);
        add(50, 1, 50, 1, 0, 40);

        // Reset state, held and just after release
        repeat (3) @(posedge clk);
        #1 check_outputs("rst_hold", 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        repeat (50) @(posedge clk);
        #1 check_outputs("post_rel", 0, 1'b0, 1'b0, 1'b0);
        repeat (PERIOD - 51) @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            bus.para_in = vecs[i].para;
            bus.dir_in  = vecs[i].dir;
            next_tick(en_cnt);
            chk($sformatf("v%0d_duty", i), int'(bus.duty_cur), vecs[i].exp_duty);
            chk($sformatf("v%0d_dir", i),  int'(bus.dir_out),  int'(vecs[i].exp_dir));
            chk($sformatf("v%0d_busy", i), int'(bus.rev_busy), int'(vecs[i].exp_busy));
            chk($sformatf("v%0d_en", i),   en_cnt,             vecs[i].exp_en);
        end

        // Reverse back to dir 0 and reset asynchronously in the middle of DEAD
        bus.dir_in = 1'b0;
        repeat (6) next_tick(en_cnt);
        chk("dead_entry_busy", int'(bus.rev_busy), 1);
        chk("dead_entry_duty", int'(bus.duty_cur), 0);
        chk("dead_entry_dir",  int'(bus.dir_out),  1);
        repeat (37) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_outputs("async_rst", 0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1 check_outputs("restart_pre", 0, 1'b0, 1'b0, 1'b0);
        next_tick(en_cnt);
        chk("restart_en", en_cnt, 0);
        chk("restart_duty", int'(bus.duty_cur), 10);
        chk("restart_busy", int'(bus.rev_busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
